// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry in-order FIFO feeding register-file writeback,
// PSR merge on commit and branch condition evaluation. Optional: PSR_BYPASS_EN.
module alu_writeback_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [7:0]         in_psr,
  input  logic [4:0]         in_flag_mask,
  input  logic [REGBITS-1:0] in_dst,
  input  logic               in_reg_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [REGBITS-1:0] out_dst,
  output logic               out_reg_we,
  output logic [7:0]         psr,
  input  logic [3:0]         cond,
  output logic               cond_true
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [WIDTH-1:0]   result;
    logic [REGBITS-1:0] dst;
    logic               we;
    logic [4:0]         flags;
    logic [4:0]         mask;
  } entry_t;

  occ_t       occ;
  entry_t     head;
  entry_t     tail;
  entry_t     in_entry;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [4:0] psr_q;
  logic [4:0] psr_next;
  logic [4:0] cond_flags;
  logic       push;
  logic       pop;
  logic       unused_psr_hi;

  assign unused_psr_hi = ^in_psr[7:5];
  assign in_entry      = '{in_result, in_dst, in_reg_we, in_psr[4:0], in_flag_mask};

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    psr_next = psr_q;
    if (pop) psr_next = (psr_q & ~head.mask) | (head.flags & head.mask);
  end

  // Head is a dedicated register so the outputs are clean after reset;
  // the tail slot only ever holds the younger of two buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ         <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head        <= '0;
      psr_q       <= '0;
    end else begin
      psr_q <= psr_next;
      unique case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head        <= in_entry;
            occ         <= OCC_ONE;
            out_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= in_entry;
          end else if (push) begin
            tail       <= in_entry;
            occ        <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            occ         <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head       <= tail;
            occ        <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          occ         <= OCC_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = head.result;
  assign out_dst    = head.dst;
  assign out_reg_we = head.we;
  assign psr        = {3'b000, psr_q};

`ifdef PSR_BYPASS_EN
  assign cond_flags = psr_next;
`else
  assign cond_flags = psr_q;
`endif

  // Flag order in cond_flags: {Z, C, F, N, L}
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'b0000: cond_true =  cond_flags[4];
      4'b0001: cond_true = ~cond_flags[4];
      4'b0010: cond_true =  cond_flags[3];
      4'b0011: cond_true = ~cond_flags[3];
      4'b0100: cond_true =  cond_flags[0];
      4'b0101: cond_true = ~cond_flags[0];
      4'b0110: cond_true =  cond_flags[1];
      4'b0111: cond_true = ~cond_flags[1];
      4'b1000: cond_true =  cond_flags[2];
      4'b1001: cond_true = ~cond_flags[2];
      4'b1010: cond_true = ~cond_flags[0] & ~cond_flags[4];
      4'b1011: cond_true =  cond_flags[0] |  cond_flags[4];
      4'b1100: cond_true = ~cond_flags[1] & ~cond_flags[4];
      4'b1101: cond_true =  cond_flags[1] |  cond_flags[4];
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage (honours PSR_BYPASS_EN).
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [7:0]  in_psr;
  logic [4:0]  in_flag_mask;
  logic [3:0]  in_dst;
  logic        in_reg_we;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_reg_we;
  logic [7:0]  psr;
  logic [3:0]  cond;
  logic        cond_true;

  int checks = 0;
  int errors = 0;

  alu_writeback_stage #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_psr(in_psr), .in_flag_mask(in_flag_mask), .in_dst(in_dst), .in_reg_we(in_reg_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_reg_we(out_reg_we),
    .psr(psr), .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] r, input logic [7:0] p, input logic [4:0] m,
                       input logic [3:0] d, input logic we);
    in_valid     = 1'b1;
    in_result    = r;
    in_psr       = p;
    in_flag_mask = m;
    in_dst       = d;
    in_reg_we    = we;
  endtask

  task automatic cond_is(input string tag, input logic [3:0] c, input logic exp);
    cond = c;
    #1;
    check(tag, {31'b0, cond_true}, {31'b0, exp});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_psr = '0; in_flag_mask = '0;
    in_dst = '0; in_reg_we = 1'b0; out_ready = 1'b0; cond = 4'b1110;

    // Reset state
    tick();
    reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_psr", {24'b0, psr}, 32'h00);
    check("rst_out_result", {16'b0, out_result}, 0);
    check("rst_out_dst", {28'b0, out_dst}, 0);
    check("rst_out_we", {31'b0, out_reg_we}, 0);
    cond_is("rst_uc", 4'b1110, 1'b1);
    cond_is("rst_eq", 4'b0000, 1'b0);
    cond_is("rst_never", 4'b1111, 1'b0);

    // Single pass-through, one-cycle latency
    out_ready = 1'b1;
    offer(16'h0000, 8'b0001_1000, 5'b11111, 4'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    check("pt_valid", {31'b0, out_valid}, 1);
    check("pt_result", {16'b0, out_result}, 32'h0000);
    check("pt_dst", {28'b0, out_dst}, 3);
    check("pt_we", {31'b0, out_reg_we}, 1);
    check("pt_psr_pre", {24'b0, psr}, 32'h00);
    tick();
    check("pt_empty", {31'b0, out_valid}, 0);
    check("pt_psr", {24'b0, psr}, 32'h18);
    cond_is("pt_eq", 4'b0000, 1'b1);
    cond_is("pt_cs", 4'b0010, 1'b1);
    cond_is("pt_fs", 4'b1000, 1'b0);

    // Backpressure: A, B accepted, C held while full
    out_ready = 1'b0;
    offer(16'haaaa, 8'h00, 5'b0, 4'd1, 1'b1);
    tick();
    check("bp_rdy1", {31'b0, in_ready}, 1);
    offer(16'h5555, 8'h00, 5'b0, 4'd2, 1'b0);
    tick();
    check("bp_full", {31'b0, in_ready}, 0);
    check("bp_headA", {16'b0, out_result}, 32'haaaa);
    offer(16'hffff, 8'h00, 5'b0, 4'd7, 1'b1);
    tick();
    check("bp_full_hold", {31'b0, in_ready}, 0);
    check("bp_hold_res", {16'b0, out_result}, 32'haaaa);
    check("bp_hold_dst", {28'b0, out_dst}, 1);
    out_ready = 1'b1;
    tick();
    check("bp_headB", {16'b0, out_result}, 32'h5555);
    check("bp_headB_we", {31'b0, out_reg_we}, 0);
    check("bp_rdy_after", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    check("bp_headC", {16'b0, out_result}, 32'hffff);
    check("bp_headC_dst", {28'b0, out_dst}, 7);
    check("bp_headC_v", {31'b0, out_valid}, 1);
    tick();
    check("bp_drained", {31'b0, out_valid}, 0);
    check("bp_psr_keep", {24'b0, psr}, 32'h18);

    // Masked merge: only N and L update
    offer(16'h0123, 8'b0000_0011, 5'b00011, 4'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("mm_psr", {24'b0, psr}, 32'h1b);
    cond_is("mm_hi", 4'b0100, 1'b1);
    cond_is("mm_lo", 4'b1010, 1'b0);
    cond_is("mm_gt", 4'b0110, 1'b1);
    cond_is("mm_eq", 4'b0000, 1'b1);
    cond_is("mm_ne", 4'b0001, 1'b0);
    cond_is("mm_ls", 4'b0101, 1'b0);
    cond_is("mm_le", 4'b0111, 1'b0);
    cond_is("mm_cc", 4'b0011, 1'b0);
    cond_is("mm_fc", 4'b1001, 1'b1);
    cond_is("mm_hs", 4'b1011, 1'b1);
    cond_is("mm_lt", 4'b1100, 1'b0);
    cond_is("mm_ge", 4'b1101, 1'b1);

    // Simultaneous push/pop at one entry keeps order
    for (int i = 1; i <= 4; i++) begin
      logic [15:0] v;
      v = 16'(i * 16'h1111);
      offer(v, 8'h00, 5'b0, 4'(i), 1'b1);
      tick();
      check("pp_head", {16'b0, out_result}, {16'b0, v});
      check("pp_rdy", {31'b0, in_ready}, 1);
      check("pp_valid", {31'b0, out_valid}, 1);
    end
    in_valid = 1'b0;
    tick();
    check("pp_drained", {31'b0, out_valid}, 0);
    check("pp_psr", {24'b0, psr}, 32'h1b);

    // Mid-operation reset with two entries buffered and psr=1F
    offer(16'h0bad, 8'b0000_0100, 5'b00100, 4'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("mr_psr_1f", {24'b0, psr}, 32'h1f);
    out_ready = 1'b0;
    offer(16'hdead, 8'h00, 5'b0, 4'd9, 1'b1);
    tick();
    offer(16'hbeef, 8'h00, 5'b0, 4'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mr_full", {31'b0, in_ready}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid", {31'b0, out_valid}, 0);
    check("mr_rdy", {31'b0, in_ready}, 1);
    check("mr_psr", {24'b0, psr}, 32'h00);
    check("mr_result", {16'b0, out_result}, 0);
    out_ready = 1'b1;
    tick();
    check("mr_no_stale", {31'b0, out_valid}, 0);

    // Same-cycle flag visibility depends on PSR_BYPASS_EN
    out_ready = 1'b0;
    offer(16'h0001, 8'b0001_0000, 5'b10000, 4'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef PSR_BYPASS_EN
    cond_is("byp_eq_same", 4'b0000, 1'b1);
`else
    cond_is("byp_eq_same", 4'b0000, 1'b0);
`endif
    check("byp_psr_reg", {24'b0, psr}, 32'h00);
    tick();
    check("byp_psr_after", {24'b0, psr}, 32'h10);
    cond_is("byp_eq_after", 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Buffers each ALU result and its raw PSR ({3'b0,Z,C,F,N,L}) in a 2-entry skid FIFO with valid/ready handshakes, and presents entries in order to register-file writeback.
- On commit, merges the selected flags into the architectural PSR register.
- Evaluates 4-bit branch condition codes against that PSR for the branch unit.

Parameters:
- WIDTH, 16, datapath width of result.
- REGBITS, 4, destination register address width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU entry valid.
- in_ready  output  1  stage can accept an entry.
- in_result  input  WIDTH  ALU result.
- in_psr  input  8  ALU flags; bit4 Z, bit3 C, bit2 F, bit1 N, bit0 L; bits 7:5 ignored.
- in_flag_mask  input  5  per-flag update enable, same bit order as in_psr[4:0].
- in_dst  input  REGBITS  destination register.
- in_reg_we  input  1  entry writes the register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_result  output  WIDTH  head result.
- out_dst  output  REGBITS  head destination.
- out_reg_we  output  1  head register-write enable; qualified by out_valid.
- psr  output  8  committed PSR; bits 7:5 always 0.
- cond  input  4  branch condition code.
- cond_true  output  1  condition satisfied.

Behaviour:
- Reset (synchronous): count=0, out_valid=0, in_ready=1, out_result=0, out_dst=0, out_reg_we=0, psr=8'h00. Reset mid-operation discards all buffered entries.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Readiness and validity: in_ready = (count<2), registered from count. out_valid = (count>0).
- Latency: an entry accepted at edge N is at the head with out_valid=1 after edge N (1 cycle). There is no combinational in-to-out bypass.
- Ordering: strict FIFO. A push and a pop in the same cycle at count=1 leaves count=1 with the new entry at head next cycle.
- Full case: at count=2, in_ready=0; any in_valid is ignored and the upstream holds its data.
- Head outputs hold stable while out_valid & ~out_ready.
- PSR commit on pop: psr[4:0] <= (psr[4:0] & ~mask) | (head_psr[4:0] & mask). psr[7:5] stays 0. An entry with mask 0 leaves psr unchanged.
- Condition evaluation is combinational from the registered psr (Z,C,F,N,L), cond to cond_true:
  - 0000 EQ Z=1; 0001 NE Z=0.
  - 0010 CS C=1; 0011 CC C=0.
  - 0100 HI L=1; 0101 LS L=0.
  - 0110 GT N=1; 0111 LE N=0.
  - 1000 FS F=1; 1001 FC F=0.
  - 1010 LO L=0&Z=0; 1011 HS L=1|Z=1.
  - 1100 LT N=0&Z=0; 1101 GE N=1|Z=1.
  - 1110 UC always 1; 1111 never 0.
- No X on outputs after reset. Payload storage needs no reset beyond the head outputs.

Optional Feature:
- Macro: PSR_BYPASS_EN.
- Defined: cond_true is evaluated on the next-PSR value, i.e. including the merge of the head entry when a pop occurs this cycle. This lets a branch see flags committing in the same cycle. The psr port remains the registered value.
- Undefined: cond_true uses the registered psr only. Flags become visible one cycle after the pop.

Test Plan:
- Reset check: reset high 1 cycle -> out_valid=0, in_ready=1, psr=8'h00; cond=1110 -> cond_true=1; cond=0000 -> 0; cond=1111 -> 0.
- Single pass-through: push result 16'h0000, psr 8'b00011000, mask 5'b11111, dst 3, reg_we=1, out_ready=1 -> out_valid=1 next cycle with result 16'h0000 and dst 3. After the pop psr=8'h18, so EQ=1, CS=1, FS=0.
- Backpressure: out_ready=0, offer A=16'haaaa, B=16'h5555, C=16'hffff back-to-back -> A and B accepted, in_ready=0, C held. Then out_ready=1 -> outputs A, B, C in order; no loss or duplication.
- Masked merge: psr=8'h18, pop entry psr 8'b00000011 with mask 5'b00011 -> psr=8'h1B; HI=1, LO=0, GT=1, EQ=1.
- Simultaneous push/pop at count=1 with out_ready=1 -> count stays 1, in_ready stays 1, order preserved over 4 consecutive entries.
- Mid-operation reset with 2 entries buffered and psr=8'h1F -> the cycle after reset: out_valid=0, in_ready=1, psr=8'h00. With PSR_BYPASS_EN, a pop of psr 8'b00010000 mask 5'b10000 with cond=0000 gives cond_true=1 in the same cycle.
